board_ctrl: RTL and testbench

Game-state controller for the tic-tac-toe board, sitting directly upstream of the square-drawing stage in the VGA pipeline. It turns mouse clicks into the 9-bit occupancy and colour vectors (`square1to9`, `square1to9_color`) that the drawing stage consumes, alternates turns, and detects win and draw conditions. Everything runs in the `pclk` domain.

---
 rtl/board_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_board_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// Tic-tac-toe game state: mouse clicks become board occupancy/colour, turn, win and draw flags.
// Click is decoded to a cell in one registered stage, then the FSM updates the board on the next edge.
module board_ctrl #(
  parameter int X0   = 262,
  parameter int Y0   = 134,
  parameter int CELL = 160,
  parameter int GAP  = 10
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        start_en,
  input  logic        choice_en,
  output logic [8:0]  square1to9,
  output logic [8:0]  square1to9_color,
  output logic        turn,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [8:0]  win_mask
);
  localparam int PITCH = CELL + GAP;

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;

  state_t     state_q, state_d;
  logic       btn_d_q, btn_d_d;
  logic       click_q, click_d;
  logic       cell_vld_q, cell_vld_d;
  logic [3:0] cell_idx_q, cell_idx_d;
  logic [8:0] square_q, square_d;
  logic [8:0] color_q, color_d;
  logic       turn_q, turn_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic [8:0] win_mask_q, win_mask_d;

  // 13-bit compare keeps base+CELL-1 from wrapping near the top of the 12-bit range.
  function automatic logic in_span(input logic [12:0] p, input int base);
    logic [12:0] lo;
    lo = 13'(base);
    return (p >= lo) && (p <= lo + 13'(CELL - 1));
  endfunction

  function automatic logic [8:0] line_mask(input int i);
    case (i)
      0:       line_mask = 9'h007;
      1:       line_mask = 9'h038;
      2:       line_mask = 9'h1C0;
      3:       line_mask = 9'h049;
      4:       line_mask = 9'h092;
      5:       line_mask = 9'h124;
      6:       line_mask = 9'h111;
      default: line_mask = 9'h054;
    endcase
  endfunction

  logic [2:0] col_hit, row_hit;
  logic [1:0] col, row;

  always_comb begin
    col_hit = '0;
    row_hit = '0;
    for (int i = 0; i < 3; i++) begin
      col_hit[i] = in_span({1'b0, mouse_xpos}, X0 + i * PITCH);
      row_hit[i] = in_span({1'b0, mouse_ypos}, Y0 + i * PITCH);
    end
    col = col_hit[2] ? 2'd2 : (col_hit[1] ? 2'd1 : 2'd0);
    row = row_hit[2] ? 2'd2 : (row_hit[1] ? 2'd1 : 2'd0);
    btn_d_d    = mouse_left;
    click_d    = mouse_left & ~btn_d_q;
    cell_vld_d = (|col_hit) & (|row_hit);
    cell_idx_d = cell_vld_d ? (4'(row) * 4'd3 + 4'(col)) : 4'd0;
  end

  logic       win_any, win_col;
  logic [8:0] win_m, line_m;

  always_comb begin
    win_any = 1'b0;
    win_col = 1'b0;
    win_m   = '0;
    line_m  = '0;
    for (int i = 0; i < 8; i++) begin
      line_m = line_mask(i);
      if ((square_q & line_m) == line_m &&
          ((color_q & line_m) == line_m || (color_q & line_m) == 9'h000)) begin
        win_any = 1'b1;
        win_col = ((color_q & line_m) == line_m);
        win_m   = win_m | line_m;
      end
    end
  end

  logic accept;
  assign accept = click_q & cell_vld_q & ~square_q[cell_idx_q];

  always_comb begin
    state_d     = state_q;
    square_d    = square_q;
    color_d     = color_q;
    turn_d      = turn_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    win_mask_d  = win_mask_q;
    // Dropping start_en wins over any move landing on the same edge.
    if (!start_en) begin
      state_d     = IDLE;
      square_d    = '0;
      color_d     = '0;
      turn_d      = 1'b0;
      game_over_d = 1'b0;
      winner_d    = 2'b00;
      win_mask_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          turn_d  = choice_en;
          state_d = PLAY;
        end
        PLAY: begin
          if (accept) begin
            square_d[cell_idx_q] = 1'b1;
            color_d[cell_idx_q]  = turn_q;
            turn_d               = ~turn_q;
            state_d              = CHECK;
          end
        end
        CHECK: begin
          if (win_any) begin
            winner_d    = win_col ? 2'b10 : 2'b01;
            win_mask_d  = win_m;
            game_over_d = 1'b1;
            state_d     = OVER;
          end else if (&square_q) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
            state_d     = OVER;
          end else begin
            state_d = PLAY;
          end
        end
        default: state_d = OVER;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= IDLE;
      btn_d_q     <= 1'b0;
      click_q     <= 1'b0;
      cell_vld_q  <= 1'b0;
      cell_idx_q  <= 4'd0;
      square_q    <= '0;
      color_q     <= '0;
      turn_q      <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
      win_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      btn_d_q     <= btn_d_d;
      click_q     <= click_d;
      cell_vld_q  <= cell_vld_d;
      cell_idx_q  <= cell_idx_d;
      square_q    <= square_d;
      color_q     <= color_d;
      turn_q      <= turn_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      win_mask_q  <= win_mask_d;
    end
  end

  assign square1to9       = square_q;
  assign square1to9_color = color_q;
  assign turn             = turn_q;
  assign game_over        = game_over_q;
  assign winner           = winner_q;
  assign win_mask         = win_mask_q;
endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl: game model per cell owner, checked every cycle, plus directed literal checks.
module tb_board_ctrl;
  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        mouse_left, start_en, choice_en;
  logic [8:0]  square1to9, square1to9_color, win_mask;
  logic        turn, game_over;
  logic [1:0]  winner;

  board_ctrl dut (
    .pclk(pclk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .mouse_left(mouse_left), .start_en(start_en), .choice_en(choice_en),
    .square1to9(square1to9), .square1to9_color(square1to9_color), .turn(turn),
    .game_over(game_over), .winner(winner), .win_mask(win_mask)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: owner[k] = -1 empty, else colour; a move lands two edges after the press edge.
  int   owner[9];
  int   lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  logic m_btn, p_clk, active, eval_pend, m_over, m_turn;
  int   p_cell;
  logic [1:0] m_win;
  logic [8:0] m_mask, m_sq, m_col;

  function automatic int cell_of(input int x, input int y);
    int c, r;
    c = -1; r = -1;
    for (int i = 0; i < 3; i++) begin
      if (x >= 262 + i * 170 && x <= 262 + i * 170 + 159) c = i;
      if (y >= 134 + i * 170 && y <= 134 + i * 170 + 159) r = i;
    end
    return (c < 0 || r < 0) ? -1 : r * 3 + c;
  endfunction

  task automatic clear_game();
    for (int k = 0; k < 9; k++) owner[k] = -1;
    m_turn = 0; m_over = 0; m_win = 0; m_mask = 0; eval_pend = 0;
  endtask

  task automatic evaluate();
    logic full, win;
    int   wc;
    full = 1; win = 0; wc = 0;
    for (int k = 0; k < 9; k++) if (owner[k] < 0) full = 0;
    for (int l = 0; l < 8; l++) begin
      if (owner[lines[l][0]] >= 0 && owner[lines[l][0]] == owner[lines[l][1]] &&
          owner[lines[l][1]] == owner[lines[l][2]]) begin
        win = 1; wc = owner[lines[l][0]];
        for (int j = 0; j < 3; j++) m_mask[lines[l][j]] = 1'b1;
      end
    end
    if (win) begin m_win = (wc == 1) ? 2'b10 : 2'b01; m_over = 1; end
    else if (full) begin m_win = 2'b11; m_over = 1; end
  endtask

  always @(posedge pclk) begin
    logic nclk;
    int   nc;
    nclk = mouse_left && !m_btn;
    nc   = cell_of(int'(mouse_xpos), int'(mouse_ypos));
    if (rst) begin
      clear_game(); active = 0; m_btn = 0; p_clk = 0; p_cell = -1;
    end else begin
      if (!start_en) begin
        clear_game(); active = 0;
      end else if (!active) begin
        active = 1; m_turn = choice_en;
      end else if (eval_pend) begin
        eval_pend = 0; evaluate();
      end else if (!m_over && p_clk && p_cell >= 0 && owner[p_cell] < 0) begin
        owner[p_cell] = int'(m_turn); m_turn = !m_turn; eval_pend = 1;
      end
      m_btn = mouse_left; p_clk = nclk; p_cell = nc;
    end
    for (int k = 0; k < 9; k++) begin
      m_sq[k]  = owner[k] >= 0;
      m_col[k] = owner[k] == 1;
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("model_square", 32'(square1to9), 32'(m_sq));
      chk("model_color", 32'(square1to9_color), 32'(m_col));
      chk("model_turn", 32'(turn), 32'(m_turn));
      chk("model_over", 32'(game_over), 32'(m_over));
      chk("model_winner", 32'(winner), 32'(m_win));
      chk("model_mask", 32'(win_mask), 32'(m_mask));
    end
  end

  task automatic press(input int k);
    mouse_xpos = 12'(342 + 170 * (k % 3));
    mouse_ypos = 12'(214 + 170 * (k / 3));
    mouse_left = 1'b1;
    @(negedge pclk);
    mouse_left = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic press_xy(input int x, input int y);
    mouse_xpos = 12'(x); mouse_ypos = 12'(y); mouse_left = 1'b1;
    @(negedge pclk);
    mouse_left = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    rst = 1; start_en = 0; choice_en = 0; mouse_left = 0; mouse_xpos = 0; mouse_ypos = 0;
    @(negedge pclk);
    chk_en = 1;
    repeat (2) @(negedge pclk);
    chk("rst_square", 32'(square1to9), 0);
    chk("rst_turn", 32'(turn), 0);
    chk("rst_winner", 32'(winner), 0);
    rst = 0; start_en = 1; choice_en = 1;
    @(negedge pclk);
    chk("start_turn", 32'(turn), 1);

    // Single move on cell 0, held for 100 cycles.
    mouse_xpos = 12'd342; mouse_ypos = 12'd214; mouse_left = 1;
    @(negedge pclk);
    chk("lat_n1_square", 32'(square1to9), 0);
    @(negedge pclk);
    chk("move_square", 32'(square1to9), 32'h001);
    chk("move_color", 32'(square1to9_color), 32'h001);
    chk("move_turn", 32'(turn), 0);
    repeat (100) @(negedge pclk);
    chk("hold_square", 32'(square1to9), 32'h001);
    chk("hold_turn", 32'(turn), 0);
    mouse_left = 0;
    repeat (3) @(negedge pclk);

    // Rejected clicks: gap, off-grid, occupied cell.
    press_xy(422, 214);
    press_xy(10, 10);
    press(0);
    chk("rej_square", 32'(square1to9), 32'h001);
    chk("rej_color", 32'(square1to9_color), 32'h001);
    chk("rej_turn", 32'(turn), 0);

    // Row win for colour 1.
    press(3); press(1); press(4);
    mouse_xpos = 12'd682; mouse_ypos = 12'd214; mouse_left = 1;
    @(negedge pclk);
    mouse_left = 0;
    @(negedge pclk);
    chk("win_n2_square", 32'(square1to9), 32'h01F);
    chk("win_n2_over", 32'(game_over), 0);
    @(negedge pclk);
    chk("win_over", 32'(game_over), 1);
    chk("win_winner", 32'(winner), 2);
    chk("win_mask", 32'(win_mask), 32'h007);
    repeat (2) @(negedge pclk);
    press(8);
    chk("over_square", 32'(square1to9), 32'h01F);
    chk("over_color", 32'(square1to9_color), 32'h007);

    // Clear, then draw game starting with colour 1.
    start_en = 0;
    @(negedge pclk);
    chk("clr_square", 32'(square1to9), 0);
    chk("clr_over", 32'(game_over), 0);
    start_en = 1; choice_en = 1;
    @(negedge pclk);
    for (int i = 0; i < 9; i++) press(draw_seq[i]);
    chk("draw_winner", 32'(winner), 3);
    chk("draw_mask", 32'(win_mask), 0);
    chk("draw_square", 32'(square1to9), 32'h1FF);
    chk("draw_color", 32'(square1to9_color), 32'h18D);

    // Abort on the same edge a move would be accepted.
    start_en = 0;
    @(negedge pclk);
    start_en = 1; choice_en = 1;
    @(negedge pclk);
    mouse_xpos = 12'd512; mouse_ypos = 12'd384; mouse_left = 1;
    @(negedge pclk);
    mouse_left = 0; start_en = 0;
    @(negedge pclk);
    chk("abort_square", 32'(square1to9), 0);
    chk("abort_color", 32'(square1to9_color), 0);
    chk("abort_turn", 32'(turn), 0);
    start_en = 1; choice_en = 0;
    @(negedge pclk);
    press(4);
    chk("restart_color", 32'(square1to9_color), 0);
    chk("restart_square", 32'(square1to9), 32'h010);
    chk("restart_turn", 32'(turn), 1);

    // Reset with a click pending in stage 1.
    mouse_xpos = 12'd342; mouse_ypos = 12'd214; mouse_left = 1;
    @(negedge pclk);
    mouse_left = 0; rst = 1;
    @(negedge pclk);
    rst = 0;
    repeat (3) @(negedge pclk);
    chk("midrst_square", 32'(square1to9), 0);
    chk("midrst_turn", 32'(turn), 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
